// File: rtl/yu_core_pkg.sv
// Shared definitions for the multi-cycle core: FSM state encoding, ALU operation
// codes, immediate format codes and the immediate extractor.
package yu_core_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // 32-bit sign-extended immediate; B and J offsets come out already scaled by 2.
    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_register_file.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is hard-wired to zero; contents are not reset.
module mc_register_file
    import yu_core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multi_cycle_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a
// single request/ready memory port, driven by an external control unit.
module multi_cycle_datapath
    import yu_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            memReq,
    output logic            memWe,
    output logic [XLEN-1:0] memAddr,
    output logic [XLEN-1:0] memWdata,
    input  logic [XLEN-1:0] memRdata,
    input  logic            memReady,
    output logic [31:0]     instr,
    output logic            zero,
    input  logic            regWrite,
    input  logic            ALUSrc,
    input  logic            memWrite,
    input  logic            memRead,
    input  logic            PCSrc,
    input  logic [1:0]      immSrc,
    input  logic [2:0]      ALUControl,
    output logic [2:0]      state
);

    localparam int AW = $clog2(NUM_REGS);

    state_e            state_q;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   old_pc;
    logic [31:0]       ir;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   mdr;
    logic              zero_q;
    logic              lat_mem_write;
    logic              lat_mem_read;
    logic              lat_reg_write;

    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic              rf_we;
    logic [XLEN-1:0]   rf_wdata;

    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   branch_target;

    assign rs1 = ir[15 +: AW];
    assign rs2 = ir[20 +: AW];
    assign rd  = ir[7 +: AW];

    mc_register_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign rf_we    = (state_q == S_WRITEBACK) && lat_reg_write && (rd != '0);
    assign rf_wdata = lat_mem_read ? mdr : alu_out;

    assign imm32   = imm_gen(ir, imm_src_e'(immSrc));
    assign imm_ext = XLEN'(imm32);

    always_comb begin
        alu_b   = ALUSrc ? imm_q : b_q;
        alu_res = a_q + alu_b;
        case (alu_op_e'(ALUControl))
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_XOR: alu_res = a_q ^ alu_b;
            ALU_SLT: alu_res = XLEN'(($signed(a_q) < $signed(alu_b)) ? 1'b1 : 1'b0);
            default: alu_res = a_q + alu_b;
        endcase
    end

    assign pc_plus4      = pc + XLEN'(4);
    assign branch_target = old_pc + imm_q;

    // Bus strobes are decoded from the state so a request is visible in the very
    // first cycle after reset release and vanishes the moment rst rises.
    assign memReq   = ~rst && ((state_q == S_FETCH) || (state_q == S_MEMORY));
    assign memWe    = (state_q == S_MEMORY) && lat_mem_write;
    assign memAddr  = (state_q == S_MEMORY) ? alu_out : pc;
    assign memWdata = b_q;

    assign instr = ir;
    assign zero  = zero_q;
    assign state = state_q;

    // Memory/writeback controls are captured in EXECUTE, keeping the bus stable
    // across ready waits regardless of control-unit glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc            <= RESET_PC;
            old_pc        <= '0;
            ir            <= '0;
            a_q           <= '0;
            b_q           <= '0;
            imm_q         <= '0;
            alu_out       <= '0;
            mdr           <= '0;
            zero_q        <= 1'b0;
            lat_mem_write <= 1'b0;
            lat_mem_read  <= 1'b0;
            lat_reg_write <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (memReady) begin
                        ir      <= 32'(memRdata);
                        old_pc  <= pc;
                        pc      <= pc_plus4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rdata1;
                    b_q     <= rdata2;
                    imm_q   <= imm_ext;
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out       <= alu_res;
                    zero_q        <= (alu_res == '0);
                    lat_mem_write <= memWrite;
                    lat_mem_read  <= memRead;
                    lat_reg_write <= regWrite;
                    if (PCSrc) begin
                        pc <= branch_target;
                    end
                    if (memRead || memWrite) begin
                        state_q <= S_MEMORY;
                    end else if (regWrite) begin
                        state_q <= S_WRITEBACK;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEMORY: begin
                    if (memReady) begin
                        if (lat_mem_write) begin
                            state_q <= S_FETCH;
                        end else begin
                            mdr     <= memRdata;
                            state_q <= S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule
